// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: an instruction-cache refill port and a data-cache port share a single
// downstream memory channel. One transaction is outstanding at a time; a watchdog aborts a
// granted transaction when mem_ack fails to arrive within TIMEOUT cycles.
//
// Configuration macro:
//   RV5STAGE_ARB_RR_EN  defined   : simultaneous requests are granted round-robin.
//                       undefined : fixed priority, data side always wins.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_valid, i_addr          instruction refill request and line address (16-byte aligned)
//   d_valid, d_we, d_addr,   data-cache request, direction, address,
//   d_wdata, d_wmask         write line and byte enables
//   i_done, d_done           one-cycle completion pulse to the owning requester
//   i_err, d_err             one-cycle timeout-abort pulse to the owning requester
//   rdata                    registered read line, valid with a done pulse
//   mem_req                  downstream request, held until mem_ack or timeout
//   mem_we, mem_addr,        latched downstream command
//   mem_wdata, mem_wmask
//   mem_ack, mem_rdata       downstream completion and read line
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [31:0]  i_addr,
    input  logic         d_valid,
    input  logic         d_we,
    input  logic [31:0]  d_addr,
    input  logic [127:0] d_wdata,
    input  logic [15:0]  d_wmask,
    output logic         i_done,
    output logic         d_done,
    output logic         i_err,
    output logic         d_err,
    output logic [127:0] rdata,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    output logic [15:0]  mem_wmask,
    input  logic         mem_ack,
    input  logic [127:0] mem_rdata
);

    localparam logic [7:0] TimeoutVal = TIMEOUT[7:0];

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StResp} state_e;

    state_e         state_q, state_d;
    logic [7:0]     wd_q, wd_d;
    logic [7:0]     wd_inc;
    logic           grant_d;
    logic           mem_req_q, mem_req_d;
    logic           mem_we_q, mem_we_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic [127:0]   mem_wdata_q, mem_wdata_d;
    logic [15:0]    mem_wmask_q, mem_wmask_d;
    logic [127:0]   rdata_q, rdata_d;
    logic           i_done_q, i_done_d;
    logic           d_done_q, d_done_d;
    logic           i_err_q, i_err_d;
    logic           d_err_q, d_err_d;

    // Line offset bits of the refill address are discarded by design.
    logic unused_i_addr_lsbs;
    assign unused_i_addr_lsbs = ^i_addr[3:0];

    assign wd_inc = wd_q + 8'd1;

`ifdef RV5STAGE_ARB_RR_EN
    // Set when the data side received the most recent grant.
    logic last_d_q;

    assign grant_d = d_valid && (!i_valid || !last_d_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else if (state_q == StIdle && (i_valid || d_valid)) begin
            last_d_q <= grant_d;
        end
    end
`else
    assign grant_d = d_valid;
`endif

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        rdata_d     = rdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        i_err_d     = 1'b0;
        d_err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_valid || d_valid) begin
                    wd_d      = '0;
                    mem_req_d = 1'b1;
                    if (grant_d) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_wmask_d = d_wmask;
                        state_d     = StBusyD;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {i_addr[31:4], 4'b0000};
                        mem_wdata_d = '0;
                        mem_wmask_d = '0;
                        state_d     = StBusyI;
                    end
                end
            end
            StBusyI, StBusyD: begin
                // An ack in the cycle the watchdog expires still completes normally.
                if (mem_ack) begin
                    rdata_d   = mem_we_q ? '0 : mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = StResp;
                    if (state_q == StBusyD) begin
                        d_done_d = 1'b1;
                    end else begin
                        i_done_d = 1'b1;
                    end
                end else if (wd_inc == TimeoutVal) begin
                    wd_d      = wd_inc;
                    mem_req_d = 1'b0;
                    state_d   = StResp;
                    if (state_q == StBusyD) begin
                        d_err_d = 1'b1;
                    end else begin
                        i_err_d = 1'b1;
                    end
                end else begin
                    wd_d = wd_inc;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wd_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            rdata_q     <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_err_q     <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            rdata_q     <= rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_err_q     <= i_err_d;
            d_err_q     <= d_err_d;
        end
    end

    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign i_err     = i_err_q;
    assign d_err     = d_err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, randomized transactions against a
// rule-level reference model, and hand-written timeout / reset / arbitration sequences.
module tb_bus_arbiter;

    localparam int unsigned TO = 255;
`ifdef RV5STAGE_ARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid, d_valid, d_we, mem_ack;
    logic [31:0]  i_addr, d_addr;
    logic [127:0] d_wdata, mem_rdata;
    logic [15:0]  d_wmask;
    logic         i_done, d_done, i_err, d_err, mem_req, mem_we;
    logic [127:0] rdata, mem_wdata;
    logic [31:0]  mem_addr;
    logic [15:0]  mem_wmask;

    int checks = 0;
    int failures = 0;

    // Reference state: which side was served last, and the line rdata must currently hold.
    bit           model_last_d;
    logic [127:0] model_rdata;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_addr(i_addr),
        .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .i_done(i_done), .d_done(d_done), .i_err(i_err), .d_err(d_err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // At most one of the four pulses may be high in any cycle.
    always @(negedge clk) begin
        if (!rst && $time > 30) begin
            checks++;
            if ($countones({i_done, d_done, i_err, d_err}) > 1) begin
                failures++;
                $display("FAIL pulse_exclusive: got %b expected at most one high",
                         {i_done, d_done, i_err, d_err});
            end
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Arbitration rule: round-robin favours the side not served last; otherwise data wins.
    function automatic bit pick_d(input bit iv, input bit dv);
        if (RrEn && iv && dv) return !model_last_d;
        return dv;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        i_valid = 0; d_valid = 0; d_we = 0; mem_ack = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0; mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_last_d = 1'b0;
        model_rdata  = '0;
    endtask

    // Runs one acked transaction starting from IDLE at a negedge; ends in IDLE at a negedge.
    task automatic txn(input logic iv, input logic dv, input logic we, input logic [31:0] ia,
                       input logic [31:0] da, input logic [127:0] wd, input logic [15:0] wm,
                       input int delay, input logic [127:0] rd, input logic ed,
                       input logic [31:0] ea, input logic ewe, input logic [127:0] ewd,
                       input logic [15:0] ewm, input logic [127:0] erd);
        i_valid = iv; d_valid = dv; d_we = we; i_addr = ia; d_addr = da;
        d_wdata = wd; d_wmask = wm;
        mem_ack = 1'b1; mem_rdata = ~rd;  // stray ack while idle
        @(negedge clk);
        mem_ack = 1'b0;
        chk("grant_req", mem_req, 1'b1);
        chk("grant_addr", mem_addr, ea);
        chk("grant_we", mem_we, ewe);
        chk("grant_wdata", mem_wdata, ewd);
        chk("grant_wmask", mem_wmask, ewm);
        chk("idle_ack_rdata", rdata, model_rdata);
        // Requester inputs change and valids drop: the transaction must carry on untouched.
        i_valid = 0; d_valid = 0; d_we = ~we; i_addr = $urandom; d_addr = $urandom;
        d_wdata = rnd128(); d_wmask = 16'($urandom);
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            chk("busy_req", mem_req, 1'b1);
            chk("busy_addr", mem_addr, ea);
            chk("busy_pulse", {i_done, d_done, i_err, d_err}, 4'b0);
        end
        mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("done_i", i_done, !ed);
        chk("done_d", d_done, ed);
        chk("done_err", {i_err, d_err}, 2'b0);
        chk("done_rdata", rdata, erd);
        chk("done_req", mem_req, 1'b0);
        mem_ack = 1'b1; mem_rdata = ~rd;  // stray ack in the response cycle
        @(negedge clk);
        mem_ack = 1'b0;
        chk("resp_ack_pulse", {i_done, d_done, i_err, d_err}, 4'b0);
        chk("resp_ack_rdata", rdata, erd);
        model_rdata  = erd;
        model_last_d = ed;
    endtask

    typedef struct {
        logic iv, dv, we;
        logic [31:0] ia, da;
        logic [127:0] wd;
        logic [15:0] wm;
        int delay;
        logic [127:0] rd;
        logic ed;
        logic [31:0] ea;
        logic ewe;
        logic [127:0] ewd;
        logic [15:0] ewm;
        logic [127:0] erd;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [3:0]   rr_pat;
        logic [3:0]   fx_pat;
        logic         ed, iv, dv, we, exp_d;
        logic [31:0]  ia, da;
        logic [127:0] wd, rd;
        logic [15:0]  wm;
        int           n, early;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_0010, 128'h0, 16'h0, 3,
                    128'h0123456789ABCDEF00112233DEADBEEF,
                    1'b1, 32'h8000_0010, 1'b0, 128'h0, 16'h0,
                    128'h0123456789ABCDEF00112233DEADBEEF};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h8000_0024, 32'h1234_5678,
                    128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5, 16'hFFFF, 0,
                    128'hCAFEF00D0000111122223333DEADC0DE,
                    1'b0, 32'h8000_0020, 1'b0, 128'h0, 16'h0,
                    128'hCAFEF00D0000111122223333DEADC0DE};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_1234,
                    128'h00112233445566778899AABBCCDDEEFF, 16'hF0F0, 1,
                    128'h11111111222222223333333344444444,
                    1'b1, 32'h0000_1234, 1'b1, 128'h00112233445566778899AABBCCDDEEFF,
                    16'hF0F0, 128'h0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 128'h0, 16'h0, 2,
                    128'h5555AAAA5555AAAA5555AAAA5555AAAA,
                    1'b0, 32'hFFFF_FFF0, 1'b0, 128'h0, 16'h0,
                    128'h5555AAAA5555AAAA5555AAAA5555AAAA};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_000F,
                    128'hFEDCBA98765432100F1E2D3C4B5A6978, 16'h0003, 5,
                    128'h13579BDF2468ACE013579BDF2468ACE0,
                    1'b1, 32'h0000_000F, 1'b0, 128'hFEDCBA98765432100F1E2D3C4B5A6978,
                    16'h0003, 128'h13579BDF2468ACE013579BDF2468ACE0};

        // Reset state, sampled while rst is still asserted.
        rst = 1'b1;
        i_valid = 0; d_valid = 0; d_we = 0; mem_ack = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0; mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_cmd", {mem_we, mem_addr, mem_wmask}, '0);
        chk("rst_wdata", mem_wdata, '0);
        chk("rst_rdata", rdata, '0);
        chk("rst_pulses", {i_done, d_done, i_err, d_err}, 4'b0);
        rst = 1'b0;
        model_last_d = 1'b0;
        model_rdata  = '0;

        foreach (vecs[v]) begin
            txn(vecs[v].iv, vecs[v].dv, vecs[v].we, vecs[v].ia, vecs[v].da, vecs[v].wd,
                vecs[v].wm, vecs[v].delay, vecs[v].rd, vecs[v].ed, vecs[v].ea, vecs[v].ewe,
                vecs[v].ewd, vecs[v].ewm, vecs[v].erd);
        end

        // Randomized transactions against the rule-level model.
        for (int t = 0; t < 40; t++) begin
            do begin
                iv = 1'($urandom); dv = 1'($urandom);
            end while (!iv && !dv);
            we = 1'($urandom); ia = $urandom; da = $urandom;
            wd = rnd128(); wm = 16'($urandom); rd = rnd128();
            ed = pick_d(iv, dv);
            txn(iv, dv, we, ia, da, wd, wm, $urandom_range(0, 6), rd, ed,
                ed ? da : {ia[31:4], 4'h0}, ed ? we : 1'b0, ed ? wd : 128'h0,
                ed ? wm : 16'h0, (ed && we) ? 128'h0 : rd);
        end

        // Ack arriving in the very cycle the watchdog expires: completion wins.
        rd = rnd128();
        txn(1'b1, 1'b0, 1'b0, 32'h0000_4448, 32'h0, 128'h0, 16'h0, int'(TO) - 1, rd,
            1'b0, 32'h0000_4440, 1'b0, 128'h0, 16'h0, rd);

        // Data write that is never acked: abort after TO request cycles.
        d_valid = 1; d_we = 1; d_addr = 32'h0000_1000; d_wdata = rnd128(); d_wmask = 16'hFFFF;
        @(negedge clk);
        chk("to_req", mem_req, 1'b1);
        d_valid = 0;
        n = 1;
        early = 0;
        for (int k = 0; k < int'(TO) + 20; k++) begin
            @(negedge clk);
            if (!mem_req) break;
            if (i_err || d_err || i_done || d_done) early++;
            n++;
        end
        chk("to_req_cycles", n, TO);
        chk("to_early_pulse", early, 0);
        chk("to_derr", d_err, 1'b1);
        chk("to_other", {i_done, d_done, i_err}, 3'b0);
        chk("to_rdata", rdata, model_rdata);
        @(negedge clk);
        chk("to_derr_once", d_err, 1'b0);
        model_last_d = 1'b1;

        // Reset during a data transaction, then a late ack.
        d_valid = 1; d_we = 1; d_addr = 32'h0000_0040; d_wdata = rnd128(); d_wmask = 16'h00FF;
        @(negedge clk);
        chk("rb_req", mem_req, 1'b1);
        @(negedge clk);
        d_valid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        mem_ack = 1; mem_rdata = rnd128();
        @(negedge clk);
        mem_ack = 0;
        chk("rb_req_after", mem_req, 1'b0);
        chk("rb_cmd", {mem_we, mem_addr, mem_wmask}, '0);
        chk("rb_wdata", mem_wdata, '0);
        chk("rb_rdata", rdata, '0);
        chk("rb_pulses", {i_done, d_done, i_err, d_err}, 4'b0);
        @(negedge clk);
        chk("rb_pulses2", {i_done, d_done, i_err, d_err}, 4'b0);
        model_last_d = 1'b0;
        model_rdata  = '0;
        rd = rnd128();
        txn(1'b1, 1'b0, 1'b0, 32'h8000_0024, 32'h0, 128'h0, 16'h0, 0, rd,
            1'b0, 32'h8000_0020, 1'b0, 128'h0, 16'h0, rd);

        // Both sides requesting continuously: grant order and minimum spacing.
        do_reset();
        rr_pat = 4'b0101;
        fx_pat = 4'b1111;
        i_valid = 1; d_valid = 1; i_addr = 32'h0000_1004; d_addr = 32'h0000_2000; d_we = 0;
        mem_rdata = rnd128();
        for (int t = 0; t < 4; t++) begin
            exp_d = RrEn ? rr_pat[t] : fx_pat[t];
            @(negedge clk);
            chk("tie_req", mem_req, 1'b1);
            chk("tie_addr", mem_addr, exp_d ? 32'h0000_2000 : 32'h0000_1000);
            mem_ack = 1;
            @(negedge clk);
            mem_ack = 0;
            chk("tie_done_d", d_done, exp_d);
            chk("tie_done_i", i_done, !exp_d);
            @(negedge clk);
            chk("tie_gap", mem_req, 1'b0);
        end
        i_valid = 0; d_valid = 0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 TIMEOUT, 255, cycles (8-bit) to wait for mem_ack before aborting a granted transaction; legal 1..255.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_valid  in  1  instruction-cache refill request; held until i_done or i_err.
REQ-005 i_addr  in  32  instruction-cache line address, 16-byte aligned.
REQ-006 d_valid  in  1  data-cache request; held until d_done or d_err.
REQ-007 d_we  in  1  data-cache write (1) or read (0).
REQ-008 d_addr  in  32  data-cache address.
REQ-009 d_wdata  in  128  data-cache write line.
REQ-010 d_wmask  in  16  data-cache byte enables.
REQ-011 i_done / d_done  out  1 each  one-cycle completion pulse to the owning requester.
REQ-012 i_err / d_err  out  1 each  one-cycle timeout-abort pulse to the owning requester.
REQ-013 rdata  out  128  registered read line; valid in the cycle of a done pulse.
REQ-014 mem_req  out  1  downstream request, held until mem_ack.
REQ-015 mem_we, mem_addr, mem_wdata, mem_wmask  out  1/32/128/16  latched downstream command.
REQ-016 mem_ack  in  1  downstream completion, one cycle.
REQ-017 mem_rdata  in  128  downstream read line, valid with mem_ack.

Function
REQ-018 FSM states: IDLE, BUSY_I, BUSY_D, plus a one-cycle RESP state; encoding is free.
REQ-019 IDLE: if any valid is high, latch the winner's command into mem_* registers, clear the watchdog, and enter BUSY_I or BUSY_D; mem_req is high from the next cycle.
REQ-020 Instruction-side grants drive mem_we=0, mem_wdata=0, mem_wmask=0, and mem_addr={i_addr[31:4],4'b0}.
REQ-021 Data-side grants pass d_addr unmodified.
REQ-022 BUSY_x: mem_* fields are held constant; requester inputs are ignored; the watchdog increments every cycle that mem_ack is low.
REQ-023 mem_ack in BUSY_x: rdata<=mem_rdata (zero for writes), mem_req<=0, x_done pulses next cycle (RESP), then IDLE.
REQ-024 Minimum latency is valid at cycle N, mem_req at N+1, mem_ack at N+1 at the earliest, done at N+2, and the next grant at N+3 at the earliest.
REQ-025 Watchdog reaching TIMEOUT with no ack: mem_req<=0, x_err pulses one cycle, rdata is unchanged, then IDLE.
REQ-026 mem_ack arriving in IDLE or RESP is ignored and does not alter rdata.
REQ-027 mem_ack in the same cycle the watchdog hits TIMEOUT: the ack wins, done pulses, err does not pulse.
REQ-028 A requester that drops valid mid-transaction does not cancel it; its done pulse is still issued.
REQ-029 done and err are never both high; at most one requester sees a pulse per cycle.
REQ-030 Only one transaction is outstanding at any time; there is no pipelining across grants.

Reset
REQ-031 On rst: state=IDLE, mem_req=0, all mem_* outputs=0, rdata=0, all done/err=0, watchdog=0, last-grant pointer=instruction (so data wins the first tie).
REQ-032 rst mid-transaction abandons the transaction with no done/err pulse; a later mem_ack is ignored per REQ-026.

Configuration
REQ-033 Macro RV5STAGE_ARB_RR_EN defined: simultaneous valids are granted round-robin; the side not served most recently wins, and the pointer updates on each grant.
REQ-034 RV5STAGE_ARB_RR_EN undefined: fixed priority, where d_valid always beats i_valid and the pointer is unused (it may be removed).

Verification
REQ-035 d_valid read at 0x80000010 with mem_ack 3 cycles after mem_req and mem_rdata=0x...DEADBEEF -> mem_addr=0x80000010, mem_we=0; one d_done pulse; rdata=0x...DEADBEEF that cycle.
REQ-036 i_valid at 0x80000024 -> mem_addr=0x80000020, mem_wmask=0; i_done pulses; d_done stays 0.
REQ-037 Both valids every cycle for 4 transactions -> with RV5STAGE_ARB_RR_EN, grants D,I,D,I; without it, D,D,D,D.
REQ-038 d_valid write with mem_ack never asserted, TIMEOUT=255 -> mem_req drops after 255 cycles; d_err pulses once; rdata unchanged.
REQ-039 rst asserted 2 cycles into BUSY_D, then mem_ack pulsed -> all outputs 0, no done/err, state IDLE; a new i_valid is granted normally.
